membus_master: RTL

MEMBUS_MASTER -- requirements
Module: membus_master

---
 rtl/membus_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/membus_master.sv
// membus_master
//   Bridges a valid/ready command/response pair onto a simple native memory
//   bus (mem_valid held until mem_ready). One transaction is in flight at a
//   time. A bus wait that runs TIMEOUT_CYCLES cycles is aborted with resp_err.
//   TIMEOUT_CYCLES=0 waits forever. TIMEOUT_CYCLES must fit in CNT_W bits.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_addr/wdata/wstrb     command fields (wstrb==0 means read)
//   resp_valid/resp_ready    response handshake
//   resp_rdata, resp_err     response fields (err = timed out)
//   mem_valid/mem_ready      native-bus request/completion
//   mem_addr/wdata/wstrb     native-bus request fields
//   mem_rdata                native-bus read data
//   dbg_state                current FSM state (0 IDLE, 1 BUS, 2 RESP)
//
// Handshake rule: a transfer happens on the rising edge where valid and ready
// are both high. valid, once raised, stays high with stable payload until
// that edge.
module membus_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  // Counter value on the last allowed wait cycle; unused when TO_EN is 0.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               mv_q, mv_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      mv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      mv_q    <= mv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    mv_d    = mv_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = '0;
          mv_d    = 1'b1;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // mem_ready is only looked at here, where mem_valid is high; a
        // completion on the timeout cycle takes priority over the abort.
        if (mem_ready) begin
          rdata_d = (wstrb_q == 4'd0) ? mem_rdata : 32'd0;
          err_d   = 1'b0;
          mv_d    = 1'b0;
          state_d = S_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          mv_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        mv_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake strobes decode straight from the state register.
  assign cmd_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = mv_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign dbg_state  = state_q;

endmodule
